// File: rtl/seven_seg_pkg.sv
// Shared types and constants for the four-digit seven-segment scanner.
// Holds the active-low off patterns, the hex segment table, the digit index
// type and the slot-phase enum used by seven_seg_scan and hex_to_seg.
package seven_seg_pkg;

  // All-off patterns for the active-low segment and anode outputs.
  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low segment codes, bit0 = a ... bit6 = g.
  // Packed so that HEX_SEG[n] selects the code for nibble value n.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

  typedef logic [1:0] digit_idx_t;

  typedef enum logic {
    DEAD = 1'b0,
    ON   = 1'b1
  } phase_t;

  // Active-low anode pattern enabling only the given digit.
  function automatic logic [3:0] an_select(input digit_idx_t idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seven_seg_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment decoder.
// Ports: nibble (4-bit value in), seg (7-bit active-low gfedcba out).
// No state, zero latency.
module hex_to_seg
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed 4-digit hex display driver with tear-free frame updates.
// Ports: clk, p_sync_reset (sync, active-high); value_i/update_i capture a
// word, blank_lz_i/dp_i shape the display; seg_o/dp_o/an_o are active-low
// registered drives, frame_o pulses once per full 4-digit scan.
module seven_seg_scan
  import seven_seg_pkg::*;
#(
  parameter int PRESCALE    = 50000,
  parameter int DEAD_CYCLES = 16
) (
  input  logic        clk,
  input  logic        p_sync_reset,
  input  logic [15:0] value_i,
  input  logic        update_i,
  input  logic        blank_lz_i,
  input  logic [3:0]  dp_i,
  output logic [6:0]  seg_o,
  output logic        dp_o,
  output logic [3:0]  an_o,
  output logic        frame_o
);

  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] CNT_DEAD = CW'(DEAD_CYCLES);

  logic [CW-1:0] cnt;
  digit_idx_t    idx;
  logic [15:0]   shadow;
  logic [15:0]   display;
  logic          pending;

  logic          slot_end;
  logic          frame_end;
  phase_t        phase;
  logic [3:0]    cur_nibble;
  logic [6:0]    cur_seg;
  logic          upper_zero;
  logic          blank_digit;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == 2'd3);
  assign phase     = (cnt < CNT_DEAD) ? DEAD : ON;

  assign cur_nibble = display[{idx, 2'b00} +: 4];

  hex_to_seg u_hex_to_seg (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

  // A digit counts as a leading zero when it and every digit to its left
  // are zero. Digit 0 is excluded so an all-zero word still shows "0".
  always_comb begin
    upper_zero = 1'b0;
    unique case (idx)
      2'd1:    upper_zero = (display[15:4]  == 12'h000);
      2'd2:    upper_zero = (display[15:8]  == 8'h00);
      2'd3:    upper_zero = (display[15:12] == 4'h0);
      default: upper_zero = 1'b0;
    endcase
  end

  assign blank_digit = blank_lz_i && upper_zero;

  // Scan position.
  always_ff @(posedge clk) begin
    if (p_sync_reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (slot_end) begin
      cnt <= '0;
      idx <= idx + 2'd1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Capture into the shadow at any time; the visible register only moves at
  // the frame boundary so a frame never mixes digits from two words. A strobe
  // landing on the boundary itself bypasses the shadow.
  always_ff @(posedge clk) begin
    if (p_sync_reset) begin
      shadow  <= '0;
      display <= '0;
      pending <= 1'b0;
    end else begin
      if (update_i) begin
        shadow  <= value_i;
        pending <= 1'b1;
      end
      if (frame_end) begin
        if (update_i) begin
          display <= value_i;
        end else if (pending) begin
          display <= shadow;
        end
        pending <= 1'b0;
      end
    end
  end

  // Registered output drives.
  always_ff @(posedge clk) begin
    if (p_sync_reset) begin
      seg_o   <= SEG_OFF;
      dp_o    <= 1'b1;
      an_o    <= AN_OFF;
      frame_o <= 1'b0;
    end else begin
      frame_o <= frame_end;
      if (phase == DEAD) begin
        seg_o <= SEG_OFF;
        dp_o  <= 1'b1;
        an_o  <= AN_OFF;
      end else begin
        seg_o <= blank_digit ? SEG_OFF : cur_seg;
        dp_o  <= ~dp_i[idx];
        an_o  <= an_select(idx);
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Self-checking bench for seven_seg_scan with PRESCALE=8, DEAD_CYCLES=2.
// Directed steps plus randomized traffic, compared every cycle against a
// cycle-count based reference model of the display behaviour.
module tb_seven_seg_scan;

  localparam int P = 8;
  localparam int D = 2;
  localparam int FRAME = 4 * P;

  logic        clk = 1'b0;
  logic        p_sync_reset = 1'b1;
  logic [15:0] value_i = '0;
  logic        update_i = 1'b0;
  logic        blank_lz_i = 1'b0;
  logic [3:0]  dp_i = '0;
  logic [6:0]  seg_o;
  logic        dp_o;
  logic [3:0]  an_o;
  logic        frame_o;

  int errors = 0;
  int checks = 0;

  seven_seg_scan #(.PRESCALE(P), .DEAD_CYCLES(D)) dut (
    .clk          (clk),
    .p_sync_reset (p_sync_reset),
    .value_i      (value_i),
    .update_i     (update_i),
    .blank_lz_i   (blank_lz_i),
    .dp_i         (dp_i),
    .seg_o        (seg_o),
    .dp_o         (dp_o),
    .an_o         (an_o),
    .frame_o      (frame_o)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: time since reset determines slot and digit; the
  // shadow/pending/display words follow the capture-and-apply rules.
  int          m_n = 0;
  logic [15:0] m_shadow = '0;
  logic [15:0] m_display = '0;
  logic        m_pending = 1'b0;
  int          frame_pulses = 0;

  task automatic check_outputs(input string tag, input logic [6:0] e_seg, input logic [3:0] e_an,
                               input logic e_dp, input logic e_frame);
    checks++;
    assert (seg_o === e_seg) else begin
      errors++;
      $error("FAIL %s seg_o: got %h expected %h (cycle %0d)", tag, seg_o, e_seg, m_n);
    end
    checks++;
    assert (an_o === e_an) else begin
      errors++;
      $error("FAIL %s an_o: got %h expected %h (cycle %0d)", tag, an_o, e_an, m_n);
    end
    checks++;
    assert (dp_o === e_dp) else begin
      errors++;
      $error("FAIL %s dp_o: got %b expected %b (cycle %0d)", tag, dp_o, e_dp, m_n);
    end
    checks++;
    assert (frame_o === e_frame) else begin
      errors++;
      $error("FAIL %s frame_o: got %b expected %b (cycle %0d)", tag, frame_o, e_frame, m_n);
    end
  endtask

  // One clock with reset asserted; the model restarts from time zero.
  task automatic rst_step(input logic [15:0] v, input logic up);
    p_sync_reset = 1'b1;
    value_i = v;
    update_i = up;
    @(posedge clk); #1;
    m_n = 0;
    m_shadow = '0;
    m_display = '0;
    m_pending = 1'b0;
    check_outputs("reset", 7'h7F, 4'hF, 1'b1, 1'b0);
  endtask

  // One normal clock: expectations come from the model state before the edge.
  task automatic step(input string tag, input logic [15:0] v, input logic up,
                      input logic blz, input logic [3:0] dpi);
    int slot, dig, nib;
    logic blanked, boundary;
    logic [6:0] e_seg;
    logic [3:0] e_an;
    logic e_dp;
    p_sync_reset = 1'b0;
    value_i = v;
    update_i = up;
    blank_lz_i = blz;
    dp_i = dpi;
    slot = m_n % P;
    dig = (m_n / P) % 4;
    boundary = (slot == P - 1) && (dig == 3);
    if (slot < D) begin
      e_seg = 7'h7F;
      e_an = 4'hF;
      e_dp = 1'b1;
    end else begin
      nib = (int'(m_display) >> (4 * dig)) & 15;
      blanked = blz && (dig > 0) && ((int'(m_display) >> (4 * dig)) == 0);
      e_seg = blanked ? 7'h7F : seg_tbl[nib];
      e_an = 4'hF & ~(4'(1) << dig);
      e_dp = ~dpi[dig];
    end
    @(posedge clk); #1;
    if (boundary) begin
      if (up) m_display = v;
      else if (m_pending) m_display = m_shadow;
    end
    if (up) m_shadow = v;
    m_pending = boundary ? 1'b0 : (up ? 1'b1 : m_pending);
    m_n++;
    if (frame_o === 1'b1) frame_pulses++;
    check_outputs(tag, e_seg, e_an, e_dp, boundary);
  endtask

  task automatic idle(input string tag, input int n, input logic blz, input logic [3:0] dpi);
    for (int i = 0; i < n; i++) step(tag, 16'h0000, 1'b0, blz, dpi);
  endtask

  // Advance until the next step lands on the given position within a frame.
  task automatic run_to(input string tag, input int pos, input logic blz);
    for (int i = 0; i < FRAME && (m_n % FRAME) != pos; i++) step(tag, 16'h0000, 1'b0, blz, 4'h0);
  endtask

  initial begin
    // Reset held three cycles.
    for (int i = 0; i < 3; i++) rst_step(16'hFFFF, 1'b1);

    // First ON phase after release shows digit 0 = "0".
    idle("release", 3, 1'b0, 4'h0);
    checks++;
    assert (an_o === 4'hE && seg_o === 7'h40) else begin
      errors++;
      $error("FAIL first_on: got an=%h seg=%h expected an=E seg=40", an_o, seg_o);
    end

    // Mid-frame update held back until the boundary, then shown a full frame.
    idle("pre_upd", 7, 1'b0, 4'h0);
    step("upd_1a2f", 16'h1A2F, 1'b1, 1'b0, 4'h0);
    frame_pulses = 0;
    idle("show_1a2f", 2 * FRAME, 1'b0, 4'h0);
    checks++;
    assert (frame_pulses === 2) else begin
      errors++;
      $error("FAIL frame_count: got %0d expected 2", frame_pulses);
    end

    // Leading-zero blanking.
    step("upd_0030", 16'h0030, 1'b1, 1'b1, 4'h0);
    idle("blank_0030", 2 * FRAME, 1'b1, 4'h0);
    step("upd_0000", 16'h0000, 1'b1, 1'b1, 4'h0);
    idle("blank_0000", 2 * FRAME, 1'b1, 4'h0);

    // Two strobes in a frame, then a third exactly on the boundary.
    run_to("align", 5, 1'b0);
    step("upd_1111", 16'h1111, 1'b1, 1'b0, 4'h0);
    idle("gap", 6, 1'b0, 4'h0);
    step("upd_2222", 16'h2222, 1'b1, 1'b0, 4'h0);
    run_to("align_b", FRAME - 1, 1'b0);
    step("upd_3333", 16'h3333, 1'b1, 1'b0, 4'h0);
    idle("show_3333", FRAME, 1'b0, 4'h0);
    checks++;
    assert (dut.display === 16'h3333) else begin
      errors++;
      $error("FAIL boundary_bypass: got display %h expected 3333", dut.display);
    end

    // Decimal point on digit 2 only.
    idle("dp2", 2 * FRAME, 1'b0, 4'b0100);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step("random", 16'($urandom), ($urandom_range(0, 15) == 0), 1'($urandom), 4'($urandom));
    end

    // Reset mid-slot on digit 2 with an update pending: capture is lost.
    step("pre_rst", 16'h0000, 1'b1, 1'b0, 4'h0);
    run_to("to_dig2", 2 * P + 4, 1'b0);
    step("pend_upd", 16'hBEEF, 1'b1, 1'b0, 4'h0);
    rst_step(16'h0000, 1'b0);
    idle("after_rst", FRAME + P, 1'b0, 4'h0);
    checks++;
    assert (dut.display === 16'h0000) else begin
      errors++;
      $error("FAIL rst_discard: got display %h expected 0000", dut.display);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
